// File: rtl/sumador_pkg.sv
// Shared definitions for the serial adder: FSM states and counter sizing.
package sumador_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // The step counter must hold the values 0 .. N/K-1.
  function automatic int cnt_width(input int n, input int k);
    return $clog2(n / k) + 1;
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// One-bit full adder; the serial adder chains K of these per clock.
module sumador_completo (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/sumador_serie.sv
// Multi-cycle adder: {cout,s} = a + b + cin, computed K bits per clock.
// Optional signed-overflow output ovf_o is built when SUMADOR_SERIE_OVF_EN
// is defined.
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] s_o,
  output logic         cout_o
`ifdef SUMADOR_SERIE_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int STEPS = N / K;
  localparam int CW = cnt_width(N, K);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
    $error("sumador_serie: need N >= 2, 1 <= K <= N and N divisible by K");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
`ifdef SUMADOR_SERIE_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic [K:0]     chainC;
  logic [K-1:0]   sliceSum;
  logic [N-1:0]   raNext;

  assign chainC[0] = carry_q;

  for (genvar i = 0; i < K; i++) begin : g_slice
    sumador_completo u_fa (
      .a_i   (ra_q[i]),
      .b_i   (rb_q[i]),
      .cin_i (chainC[i]),
      .s_o   (sliceSum[i]),
      .cout_o(chainC[i+1])
    );
  end

  // Operand A and the partial sum share one register: as A moves right by K,
  // the freshly produced sum bits fill the vacated top. After N/K steps the
  // register holds the whole sum.
  if (K < N) begin : g_shift
    assign raNext = {sliceSum, ra_q[N-1:K]};
  end else begin : g_whole
    assign raNext = sliceSum;
  end

  // Next-state logic: accept operands, step the slice chain, publish the result.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SUMADOR_SERIE_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          ra_d    = a_i;
          rb_d    = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ra_d    = raNext;
        rb_d    = rb_q >> K;
        carry_d = chainC[K];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          s_d     = raNext;
          cout_d  = chainC[K];
`ifdef SUMADOR_SERIE_OVF_EN
          ovf_d   = chainC[K] ^ chainC[K-1];
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign cout_o = cout_q;
`ifdef SUMADOR_SERIE_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie: one N=8/K=1 instance and one
// N=8/K=4 instance, checked against an arithmetic reference model.
// Overflow checks are compiled in when SUMADOR_SERIE_OVF_EN is defined.
module tb_sumador_serie;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] aIn, bIn;
  logic       cinIn;

  logic       busy1, done1, cout1;
  logic [7:0] s1;
  logic       busy4, done4, cout4;
  logic [7:0] s4;
`ifdef SUMADOR_SERIE_OVF_EN
  logic       ovf1, ovf4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sumador_serie #(.N(8), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1),
    .a_i(aIn), .b_i(bIn), .cin_i(cinIn),
    .busy_o(busy1), .done_o(done1), .s_o(s1), .cout_o(cout1)
`ifdef SUMADOR_SERIE_OVF_EN
    , .ovf_o(ovf1)
`endif
  );

  sumador_serie #(.N(8), .K(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4),
    .a_i(aIn), .b_i(bIn), .cin_i(cinIn),
    .busy_o(busy4), .done_o(done4), .s_o(s4), .cout_o(cout4)
`ifdef SUMADOR_SERIE_OVF_EN
    , .ovf_o(ovf4)
`endif
  );

  // Reference model: plain 9-bit addition and the signed-overflow rule.
  function automatic logic [8:0] refSum(input logic [7:0] a, input logic [7:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic refOvf(input logic [7:0] a, input logic [7:0] b,
                                  input logic c);
    int sa, sb, total;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    total = sa + sb + int'(c);
    return (total > 127) || (total < -128);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on the chosen instance and follow it to its done cycle.
  task automatic applyStimulus(input int which, input logic [7:0] a,
                               input logic [7:0] b, input logic c,
                               output int lat, output int busyCnt, output int bothHigh,
                               output logic [7:0] sOut, output logic coutOut,
                               output logic ovfOut);
    logic curBusy, curDone;
    aIn = a;
    bIn = b;
    cinIn = c;
    if (which == 1) start1 = 1'b1;
    else start4 = 1'b1;
    nextCycle();
    start1 = 1'b0;
    start4 = 1'b0;
    aIn = 8'($urandom);
    bIn = 8'($urandom);
    cinIn = 1'($urandom_range(1, 0));
    lat = 0;
    busyCnt = 0;
    bothHigh = 0;
    while (lat < 40) begin
      curBusy = (which == 1) ? busy1 : busy4;
      curDone = (which == 1) ? done1 : done4;
      if (curBusy && curDone) bothHigh++;
      if (curDone) break;
      if (curBusy) busyCnt++;
      nextCycle();
      lat++;
    end
    sOut = (which == 1) ? s1 : s4;
    coutOut = (which == 1) ? cout1 : cout4;
`ifdef SUMADOR_SERIE_OVF_EN
    ovfOut = (which == 1) ? ovf1 : ovf4;
`else
    ovfOut = 1'b0;
`endif
  endtask

  // Run one operation and compare everything against the reference model.
  task automatic runModelOp(input int which, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input string tag);
    int lat, busyCnt, bothHigh;
    logic [7:0] sOut;
    logic coutOut, ovfOut;
    logic [8:0] expSum;
    int expLat;
    expLat = (which == 1) ? 8 : 2;
    expSum = refSum(a, b, c);
    applyStimulus(which, a, b, c, lat, busyCnt, bothHigh, sOut, coutOut, ovfOut);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busyCycles"}, busyCnt, expLat);
    checkOutput({tag, "_busyAndDone"}, bothHigh, 0);
    checkOutput({tag, "_sum"}, int'(sOut), int'(expSum[7:0]));
    checkOutput({tag, "_cout"}, int'(coutOut), int'(expSum[8]));
`ifdef SUMADOR_SERIE_OVF_EN
    checkOutput({tag, "_ovf"}, int'(ovfOut), int'(refOvf(a, b, c)));
`endif
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expS;
    logic       expCout;
    logic       expOvf;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int lat, busyCnt, bothHigh, doneSeen, edges;
    logic [7:0] sOut;
    logic coutOut, ovfOut;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};

    rst_n = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    aIn = 8'h00;
    bIn = 8'h00;
    cinIn = 1'b0;

    // Reset values, visible before any clock edge.
    #1;
    checkOutput("reset_busy1", int'(busy1), 0);
    checkOutput("reset_done1", int'(done1), 0);
    checkOutput("reset_s1", int'(s1), 0);
    checkOutput("reset_cout1", int'(cout1), 0);
    checkOutput("reset_busy4", int'(busy4), 0);
    checkOutput("reset_s4", int'(s4), 0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("idle_busy1", int'(busy1), 0);

    // Directed table on the one-bit-per-cycle instance.
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].cin, lat, busyCnt, bothHigh,
                    sOut, coutOut, ovfOut);
      checkOutput($sformatf("vec%0d_latency", i), lat, 8);
      checkOutput($sformatf("vec%0d_busyCycles", i), busyCnt, 8);
      checkOutput($sformatf("vec%0d_sum", i), int'(sOut), int'(vecs[i].expS));
      checkOutput($sformatf("vec%0d_cout", i), int'(coutOut), int'(vecs[i].expCout));
`ifdef SUMADOR_SERIE_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), int'(ovfOut), int'(vecs[i].expOvf));
`endif
      nextCycle();
      checkOutput($sformatf("vec%0d_donePulse", i), int'(done1), 0);
      checkOutput($sformatf("vec%0d_idleBusy", i), int'(busy1), 0);
      checkOutput($sformatf("vec%0d_sumHold", i), int'(s1), int'(vecs[i].expS));
      checkOutput($sformatf("vec%0d_coutHold", i), int'(cout1), int'(vecs[i].expCout));
    end

    // start pulsed mid-operation with other operands must be ignored.
    nextCycle();
    aIn = 8'h12;
    bIn = 8'h34;
    cinIn = 1'b1;
    start1 = 1'b1;
    nextCycle();
    start1 = 1'b0;
    edges = 1;
    repeat (3) begin
      nextCycle();
      edges++;
    end
    aIn = 8'hAA;
    bIn = 8'h55;
    cinIn = 1'b0;
    start1 = 1'b1;
    nextCycle();
    edges++;
    start1 = 1'b0;
    while (!done1 && edges < 40) begin
      nextCycle();
      edges++;
    end
    checkOutput("midRunStart_latency", edges - 1, 8);
    checkOutput("midRunStart_sum", int'(s1), 8'h47);
    checkOutput("midRunStart_cout", int'(cout1), 0);
    nextCycle();
    checkOutput("midRunStart_noSecondOp", int'(busy1), 0);

    // Back-to-back: start held in the DONE cycle launches the next operation directly.
    nextCycle();
    runModelOp(1, 8'h5A, 8'h3C, 1'b0, "b2bFirst");
    checkOutput("b2b_inDone", int'(done1), 1);
    runModelOp(1, 8'h01, 8'h02, 1'b1, "b2bSecond");
    checkOutput("b2b_secondSum", int'(s1), 8'h04);

    // Asynchronous reset mid-operation.
    nextCycle();
    aIn = 8'hFF;
    bIn = 8'hFF;
    cinIn = 1'b1;
    start1 = 1'b1;
    nextCycle();
    start1 = 1'b0;
    repeat (3) nextCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", int'(busy1), 0);
    checkOutput("midReset_done", int'(done1), 0);
    checkOutput("midReset_s", int'(s1), 0);
    checkOutput("midReset_cout", int'(cout1), 0);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      if (done1 || busy1) doneSeen++;
    end
    checkOutput("midReset_noDoneAfter", doneSeen, 0);
    runModelOp(1, 8'hC3, 8'h5E, 1'b1, "postReset");

    // Random operations on both instances.
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(1, 0) == 1) nextCycle();
      runModelOp(1, 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)), "rndK1");
    end
    nextCycle();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) nextCycle();
      runModelOp(4, 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)), "rndK4");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
